// File: rtl/hdc_enc_pkg.sv
// Shared types and constants for the HDC encode scheduler and its quantise lanes.
package hdc_enc_pkg;

    localparam int unsigned FP32_W     = 32;
    localparam int unsigned NUM_LEVELS = 10;
    localparam int unsigned NUM_THRESH = 9;

    // Quantisation thresholds t_k = -8/9 + 2k/9 as IEEE-754 single, k = 0..8
    localparam logic [FP32_W-1:0] THRESH [NUM_THRESH] = '{
        32'hBF638E39,   // -8/9
        32'hBF2AAAAB,   // -2/3
        32'hBEE38E39,   // -4/9
        32'hBE638E39,   // -2/9
        32'h00000000,   //  0
        32'h3E638E39,   //  2/9
        32'h3EE38E39,   //  4/9
        32'h3F2AAAAB,   //  2/3
        32'h3F638E39    //  8/9
    };

    typedef logic [3:0] level_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Beats needed to carry nf features through the given number of lanes
    function automatic int unsigned num_beats(input int unsigned nf, input int unsigned lanes);
        return (nf + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/hdc_quant_lane.sv
// Combinational FP32 -> quantisation level -> one-hot HV segment for one feature.
// Comparisons are sign-magnitude on raw bits; +0 and -0 compare equal, NaN maps to level 4.
module hdc_quant_lane
    import hdc_enc_pkg::*;
#(
    parameter int unsigned HV_SEG_W = NUM_LEVELS
) (
    input  logic [FP32_W-1:0]   x,
    output logic [HV_SEG_W-1:0] seg_c
);

    level_t level;
    logic   is_nan;

    // Strict a > b for IEEE-754 single without an FP unit
    function automatic logic fp_gt(input logic [FP32_W-1:0] a, input logic [FP32_W-1:0] b);
        logic [FP32_W-2:0] am;
        logic [FP32_W-2:0] bm;
        logic              res;
        am = a[FP32_W-2:0];
        bm = b[FP32_W-2:0];
        res = 1'b0;
        if (!(am == '0 && bm == '0)) begin
            case ({a[FP32_W-1], b[FP32_W-1]})
                2'b01:   res = 1'b1;
                2'b10:   res = 1'b0;
                2'b00:   res = (am > bm);
                default: res = (am < bm);
            endcase
        end
        return res;
    endfunction

    assign is_nan = (&x[30:23]) && (|x[22:0]);

    // Level is the number of thresholds strictly below x; LUT is one-hot on the level
    always_comb begin
        level = '0;
        for (int k = 0; k < NUM_THRESH; k++) begin
            if (fp_gt(x, THRESH[k])) begin
                level = level + level_t'(1);
            end
        end
        if (is_nan) begin
            level = level_t'(4);
        end
        seg_c = HV_SEG_W'(1) << level;
    end

endmodule

// File: rtl/hdc_encode_scheduler.sv
// Streams one sample of FP32 features through LANES shared quantise lanes as
// fixed-width beats, masking the partial final beat, with a one-deep output register.
// Optional: define HDC_SAT_STATS_EN to add the sat_count port (saturated-feature counter).
module hdc_encode_scheduler
    import hdc_enc_pkg::*;
#(
    parameter int unsigned NUM_FEATURES = 617,
    parameter int unsigned LANES        = 8,
    parameter int unsigned FP_W         = 32,
    parameter int unsigned HV_SEG_W     = 10
) (
    input  logic                                             clk,
    input  logic                                             nrst,
    input  logic                                             en,
    input  logic                                             start,
    output logic                                             busy,
    output logic                                             done,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [LANES*FP_W-1:0]                            in_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [$clog2(num_beats(NUM_FEATURES, LANES))-1:0] out_beat,
    output logic [LANES*HV_SEG_W-1:0]                        out_hv,
    output logic [LANES-1:0]                                 out_mask,
    output logic                                             out_last
`ifdef HDC_SAT_STATS_EN
    ,
    output logic [$clog2(NUM_FEATURES+1)-1:0]                sat_count
`endif
);

    localparam int unsigned NUM_BEATS = num_beats(NUM_FEATURES, LANES);
    localparam int unsigned BEAT_W    = $clog2(NUM_BEATS);
    localparam int unsigned HV_W      = LANES * HV_SEG_W;

    state_t            state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [HV_W-1:0]   hv_c;
    logic [LANES-1:0]  mask_c;
    logic              accept_c;
    logic              out_hs_c;
    logic              last_in_c;

    // Single output register, no skid: accept only when the register is free or draining
    assign in_ready  = en && (state == STREAM) && (!out_valid || out_ready);
    assign accept_c  = in_valid && in_ready;
    assign out_hs_c  = en && out_valid && out_ready;
    assign last_in_c = (beat_cnt == BEAT_W'(NUM_BEATS - 1));

    // Quantise lanes; lanes past the last feature are masked to a zero segment
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [HV_SEG_W-1:0] seg;

        hdc_quant_lane #(
            .HV_SEG_W (HV_SEG_W)
        ) u_lane (
            .x     (in_data[i*FP_W +: FP32_W]),
            .seg_c (seg)
        );

        assign mask_c[i] = (32'(beat_cnt) * LANES + 32'(i)) < NUM_FEATURES;
        assign hv_c[i*HV_SEG_W +: HV_SEG_W] = mask_c[i] ? seg : '0;
    end

`ifdef HDC_SAT_STATS_EN
    localparam int unsigned SAT_W = $clog2(NUM_FEATURES + 1);

    logic [SAT_W-1:0] sat_beat_c;

    // Saturated lanes in the held beat: level 0 or level 9 bit set (masked lanes are zero)
    always_comb begin
        sat_beat_c = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_beat_c = sat_beat_c + SAT_W'(out_hv[i*HV_SEG_W])
                                    + SAT_W'(out_hv[i*HV_SEG_W + HV_SEG_W - 1]);
        end
    end

    // Per-sample saturation counter, cleared on an accepted start
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sat_count <= '0;
        end else if (en) begin
            if (state == IDLE && start) begin
                sat_count <= '0;
            end else if (out_hs_c) begin
                sat_count <= sat_count + sat_beat_c;
            end
        end
    end
`endif

    // Sequencer FSM, beat counter and output register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_hv    <= '0;
            out_mask  <= '0;
            out_beat  <= '0;
        end else if (en) begin
            done <= 1'b0;

            if (accept_c) begin
                out_valid <= 1'b1;
                out_hv    <= hv_c;
                out_mask  <= mask_c;
                out_beat  <= beat_cnt;
                out_last  <= last_in_c;
            end else if (out_hs_c) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= STREAM;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (accept_c) begin
                        if (last_in_c) begin
                            state    <= DRAIN;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdc_encode_scheduler.sv
// Randomised self-checking bench for hdc_encode_scheduler against a real-valued
// reference of the quantiser and a queue model of the beat stream.
`timescale 1ns/1ps
module tb_hdc_encode_scheduler;

    localparam int unsigned NF   = 617;
    localparam int unsigned LN   = 8;
    localparam int unsigned FPW  = 32;
    localparam int unsigned SEGW = 10;
    localparam int unsigned NB   = (NF + LN - 1) / LN;
    localparam int unsigned BW   = $clog2(NB);
    localparam int unsigned SATW = $clog2(NF + 1);
    localparam int          LIMIT = 4000;

    logic               clk = 1'b0;
    logic               nrst, en, start, in_valid, out_ready;
    logic               busy, done, in_ready, out_valid, out_last;
    logic [LN*FPW-1:0]  in_data;
    logic [BW-1:0]      out_beat;
    logic [LN*SEGW-1:0] out_hv;
    logic [LN-1:0]      out_mask;
`ifdef HDC_SAT_STATS_EN
    logic [SATW-1:0]    sat_count;
`endif

    always #5 clk = ~clk;

    hdc_encode_scheduler #(
        .NUM_FEATURES (NF),
        .LANES        (LN),
        .FP_W         (FPW),
        .HV_SEG_W     (SEGW)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_beat  (out_beat),
        .out_hv    (out_hv),
        .out_mask  (out_mask),
        .out_last  (out_last)
`ifdef HDC_SAT_STATS_EN
        ,
        .sat_count (sat_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] feat [NF];
    int          q [$];
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_sat  = 0;
    int          in_idx = NB;
    int          beats_out = 0;
    int          done_cnt  = 0;
    bit          dir_chk   = 0;
    logic [9:0]  dir_seg [5];
    logic [31:0] near_thr [8];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Exact real value of a finite FP32 pattern
    function automatic real fp_val(input logic [31:0] x);
        real v;
        int  e;
        if (x[30:23] == 8'd0) begin
            v = real'(x[22:0]);
            e = -149;
        end else begin
            v = real'(x[22:0]) + 8388608.0;
            e = int'(x[30:23]) - 150;
        end
        if (e > 0) repeat (e) v = v * 2.0;
        else       repeat (-e) v = v / 2.0;
        return x[31] ? -v : v;
    endfunction

    // level = #{k : x > -8/9 + 2k/9}, with the special cases for Inf/NaN
    function automatic int ref_level(input logic [31:0] x);
        real v;
        int  lvl;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 0) return 4;
            return x[31] ? 0 : 9;
        end
        v = fp_val(x);
        lvl = 0;
        for (int k = 0; k < 9; k++) if (v * 9.0 > -8.0 + 2.0 * k) lvl++;
        return lvl;
    endfunction

    function automatic logic [LN*SEGW-1:0] exp_hv(input int b);
        logic [LN*SEGW-1:0] hv;
        hv = '0;
        for (int i = 0; i < LN; i++)
            if (b * LN + i < NF) hv[i*SEGW + ref_level(feat[b*LN+i])] = 1'b1;
        return hv;
    endfunction

    function automatic logic [LN-1:0] exp_mask(input int b);
        logic [LN-1:0] m;
        for (int i = 0; i < LN; i++) m[i] = (b * LN + i < NF);
        return m;
    endfunction

    function automatic int exp_sat(input int b);
        int n, l;
        n = 0;
        for (int i = 0; i < LN; i++) begin
            if (b * LN + i < NF) begin
                l = ref_level(feat[b*LN+i]);
                if (l == 0 || l == 9) n++;
            end
        end
        return n;
    endfunction

    // Masked lanes carry garbage so masking is exercised
    function automatic logic [LN*FPW-1:0] pack_beat(input int b);
        logic [LN*FPW-1:0] d;
        for (int i = 0; i < LN; i++)
            d[i*FPW +: FPW] = (b * LN + i < NF) ? feat[b*LN+i] : $urandom();
        return d;
    endfunction

    function automatic bit is_exact_thr(input logic [31:0] x);
        for (int i = 0; i < 8; i++) if (x == near_thr[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rnd_feat();
        int          r;
        logic [31:0] x;
        r = $urandom_range(99);
        if (r < 65)      x = {1'($urandom()), 8'($urandom_range(128, 118)), 23'($urandom())};
        else if (r < 75) begin
            x = near_thr[$urandom_range(7)];
            x = ($urandom_range(1) == 1) ? x + 32'd1 : x - 32'd1;
        end
        else if (r < 81) x = {1'($urandom()), 31'd0};
        else if (r < 86) x = {1'($urandom()), 8'hFF, 23'd0};
        else if (r < 89) x = {1'($urandom()), 8'hFF, 23'($urandom()) | 23'd1};
        else if (r < 94) x = {1'($urandom()), 8'd0, 23'($urandom())};
        else begin
            x = $urandom();
            while (is_exact_thr(x)) x = $urandom();
        end
        return x;
    endfunction

    // One clock: drive inputs, check in_ready, clock, update model, check outputs
    task automatic step(input logic st, input logic e, input logic v, input logic r);
        bit exp_rdy, acc, hs, was_busy;
        int b;
        start     = st;
        en        = e;
        in_valid  = v;
        out_ready = r;
        in_data   = pack_beat(in_idx);
        #1;
        exp_rdy = e && m_busy && (in_idx < NB) && (q.size() == 0 || r);
        check_eq("in_ready", in_ready, exp_rdy);
        acc = exp_rdy && v;
        hs  = e && (q.size() != 0) && r;
        was_busy = m_busy;
        @(posedge clk);
        #1;
        if (e) begin
            m_done = 0;
            if (hs) begin
                b = q.pop_front();
                beats_out++;
                m_sat += exp_sat(b);
                if (b == NB - 1) begin
                    m_busy = 0;
                    m_done = 1;
                    done_cnt++;
                end
            end
            if (acc) begin
                q.push_back(in_idx);
                in_idx++;
            end
            if (st && !was_busy) begin
                m_busy = 1;
                in_idx = 0;
                m_sat  = 0;
            end
        end
        check_eq("busy", busy, m_busy);
        check_eq("done", done, m_done);
        check_eq("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("out_beat", out_beat, q[0]);
            check_eq("out_hv", out_hv, exp_hv(q[0]));
            check_eq("out_mask", out_mask, exp_mask(q[0]));
            check_eq("out_last", out_last, q[0] == NB - 1);
            if (q[0] == NB - 1) begin
                check_eq("last_mask_01", out_mask, 8'h01);
                check_eq("last_hv_hi_zero", out_hv[LN*SEGW-1:SEGW], '0);
            end
            if (dir_chk && q[0] < 5)
                check_eq("lane0_seg", out_hv[SEGW-1:0], dir_seg[q[0]]);
        end
`ifdef HDC_SAT_STATS_EN
        check_eq("sat_count", sat_count, m_sat);
`endif
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next edge
    task automatic do_reset();
        nrst = 1'b0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_out_hv", out_hv, 0);
        check_eq("rst_out_mask", out_mask, 0);
        check_eq("rst_out_beat", out_beat, 0);
        check_eq("rst_in_ready", in_ready, 0);
`ifdef HDC_SAT_STATS_EN
        check_eq("rst_sat_count", sat_count, 0);
`endif
        m_busy = 0;
        m_done = 0;
        m_sat  = 0;
        in_idx = NB;
        q.delete();
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    // win_kind 0: out_ready low 5 cycles; 1: en low 3 cycles with in_valid high
    task automatic run_sample(input int rdy_pct, input int en_off_pct, input int vld_pct,
                              input int win_at, input int win_kind, input int rst_at,
                              input bit stray, input bit fast);
        int  cyc, beats0, done0, win_left;
        bit  fired, was_reset;
        logic e, v, r, st;
        cyc = 0;
        beats0 = beats_out;
        done0 = done_cnt;
        fired = 0;
        was_reset = 0;
        win_left = 0;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        while (m_busy && cyc < LIMIT) begin
            if (rst_at >= 0 && in_idx >= rst_at) begin
                do_reset();
                was_reset = 1;
                break;
            end
            e  = ($urandom_range(99) >= en_off_pct);
            v  = ($urandom_range(99) < vld_pct);
            r  = ($urandom_range(99) < rdy_pct);
            st = stray && ($urandom_range(99) < 8);
            if (win_at >= 0 && !fired && in_idx >= win_at) begin
                fired = 1;
                win_left = (win_kind == 0) ? 5 : 3;
            end
            if (win_left > 0) begin
                win_left--;
                e = (win_kind == 0);
                v = 1'b1;
                r = (win_kind != 0);
            end
            step(st, e, v, r);
            cyc++;
        end
        check_eq("no_timeout", cyc < LIMIT, 1);
        if (!was_reset) begin
            check_eq("beats_per_sample", beats_out - beats0, NB);
            check_eq("done_once", done_cnt - done0, 1);
            if (fast) check_eq("fullspeed_cycles", cyc, NB + 1);
            step(1'b0, 1'b1, 1'b0, 1'b1);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NF; i++) feat[i] = rnd_feat();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        near_thr = '{32'hBF638E39, 32'hBF2AAAAB, 32'hBEE38E39, 32'hBE638E39,
                     32'h3E638E39, 32'h3EE38E39, 32'h3F2AAAAB, 32'h3F638E39};
        dir_seg  = '{10'b1000000000, 10'b0100000000, 10'b0000100000,
                     10'b0000010000, 10'b0000000001};
        nrst = 1'b1; en = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0;
        #1 nrst = 1'b0;
        #2;
        check_eq("init_busy", busy, 0);
        check_eq("init_done", done, 0);
        check_eq("init_out_valid", out_valid, 0);
        check_eq("init_out_last", out_last, 0);
        check_eq("init_out_hv", out_hv, 0);
        check_eq("init_out_mask", out_mask, 0);
        check_eq("init_out_beat", out_beat, 0);
        @(posedge clk);
        #1 nrst = 1'b1;

        // A start while en=0 is lost
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);

        // Directed lane-0 values plus specials, full throughput
        fill_random();
        feat[0]  = 32'h3F800000;
        feat[8]  = 32'h3F333333;
        feat[16] = 32'h3DCCCCCD;
        feat[24] = 32'hBDCCCCCD;
        feat[32] = 32'hBF800000;
        feat[1] = 32'h00000000; feat[2] = 32'h80000000; feat[3] = 32'h7F800000;
        feat[4] = 32'hFF800000; feat[5] = 32'h7FC00000; feat[6] = 32'h00000001;
        feat[7] = 32'h80000001;
        dir_chk = 1;
        run_sample(100, 0, 100, -1, 0, -1, 1'b0, 1'b1);
        dir_chk = 0;

        // Random backpressure/enable/valid gaps, stray starts, 5-cycle out_ready stall
        fill_random();
        run_sample(70, 10, 80, 20, 0, -1, 1'b1, 1'b0);

        // en low 3 cycles with in_valid high
        fill_random();
        run_sample(100, 0, 100, 30, 1, -1, 1'b1, 1'b0);

        // Reset at beat 40, then a fresh sample restarts from beat 0
        fill_random();
        run_sample(90, 0, 100, -1, 0, 40, 1'b0, 1'b0);
        fill_random();
        run_sample(80, 5, 90, -1, 0, -1, 1'b0, 1'b0);

        // All +-1.0: every feature saturates
        for (int i = 0; i < NF; i++) feat[i] = ($urandom_range(1) == 1) ? 32'hBF800000 : 32'h3F800000;
        run_sample(85, 0, 95, -1, 0, -1, 1'b0, 1'b0);
`ifdef HDC_SAT_STATS_EN
        check_eq("sat_all_617", sat_count, 617);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
